// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: branch conditions, trap causes, FSM states.
// Pure definitions; no logic, no latency, no flow control.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        COND_BEQ  = 2'd0,
        COND_BNE  = 2'd1,
        COND_BLEZ = 2'd2,
        COND_BGTZ = 2'd3
    } cond_mode_e;

    localparam logic [1:0] CAUSE_OVF   = 2'd0;
    localparam logic [1:0] CAUSE_OPC   = 2'd1;
    localparam logic [1:0] CAUSE_RSVD  = 2'd2;
    localparam logic [1:0] CAUSE_ALIGN = 2'd3;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

endpackage

// File: rtl/pc_cond_eval.sv
// Branch condition evaluator from ALU flags; purely combinational, no backpressure.
module pc_cond_eval
    import pc_sequencer_pkg::*;
(
    input  logic [1:0] cond_mode,
    input  logic       alu_zero,
    input  logic       alu_neg,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond_mode_e'(cond_mode))
            COND_BEQ:  cond_true = alu_zero;
            COND_BNE:  cond_true = !alu_zero;
            COND_BLEZ: cond_true = alu_zero | alu_neg;
            COND_BGTZ: cond_true = !alu_zero & !alu_neg;
            default:   cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC register with source mux, branch qualification and a one-cycle trap state.
// Writes land in pc_q one cycle after the strobe; no backpressure, strobes in TRAP are dropped.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               NSRC     = 6,
    parameter int               SELW     = 3,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h0000_00FC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NSRC*WIDTH-1:0] src_in,
    input  logic [SELW-1:0]       pc_sel,
    input  logic                  pc_write,
    input  logic                  pc_write_cond,
    input  logic [1:0]            cond_mode,
    input  logic                  alu_zero,
    input  logic                  alu_neg,
    input  logic                  exc_req,
    input  logic [1:0]            exc_code,
    output logic [WIDTH-1:0]      pc_next,
    output logic [WIDTH-1:0]      pc_q,
    output logic [WIDTH-1:0]      epc_q,
    output logic [1:0]            cause_q,
    output logic                  trap_active,
    output logic                  sel_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_d, epc_d;
    logic [1:0]       cause_d;
    logic             sel_err_q, sel_err_d;
    logic             sel_ok;
    logic             cond_true;
    logic             do_write;

    // Out-of-range selects fall back to the current PC so the mux never latches.
    always_comb begin
        pc_next = pc_q;
        sel_ok  = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (pc_sel == SELW'(k)) begin
                pc_next = src_in[k*WIDTH +: WIDTH];
                sel_ok  = 1'b1;
            end
        end
    end

    pc_cond_eval u_cond_eval (
        .cond_mode (cond_mode),
        .alu_zero  (alu_zero),
        .alu_neg   (alu_neg),
        .cond_true (cond_true)
    );

    assign do_write    = pc_write | (pc_write_cond & cond_true);
    assign trap_active = (state_q == ST_TRAP);
    assign sel_err     = sel_err_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        sel_err_d = sel_err_q;
        case (state_q)
            ST_RUN: begin
                if (exc_req) begin
                    epc_d   = pc_q;
                    cause_d = exc_code;
                    state_d = ST_TRAP;
                end else if (do_write) begin
                    if (!sel_ok) begin
                        sel_err_d = 1'b1;
                    end else if (pc_next[1:0] != 2'b00) begin
                        epc_d   = pc_q;
                        cause_d = CAUSE_ALIGN;
                        state_d = ST_TRAP;
                    end else begin
                        pc_d = pc_next;
                    end
                end
            end
            ST_TRAP: begin
                // Vector table has one word per cause; sum wraps at WIDTH bits.
                pc_d    = EXC_VEC + (WIDTH'(cause_q) << 2);
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            epc_q     <= '0;
            cause_q   <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            sel_err_q <= sel_err_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: driver queues hand-computed post-edge state, monitor compares.
module tb_pc_sequencer;

    localparam int W = 32;
    localparam int N = 6;
    localparam int S = 3;

    typedef struct {
        string      name;
        logic [W-1:0] pc;
        logic [W-1:0] epc;
        logic [1:0] cause;
        logic       trap;
        logic       serr;
    } exp_t;

    logic           clk;
    logic           reset;
    logic [N*W-1:0] src_in;
    logic [S-1:0]   pc_sel;
    logic           pc_write, pc_write_cond;
    logic [1:0]     cond_mode;
    logic           alu_zero, alu_neg;
    logic           exc_req;
    logic [1:0]     exc_code;
    logic [W-1:0]   pc_next, pc_q, epc_q;
    logic [1:0]     cause_q;
    logic           trap_active, sel_err;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   drv_done = 0;

    pc_sequencer #(.WIDTH(W), .NSRC(N), .SELW(S)) dut (
        .clk           (clk),
        .reset         (reset),
        .src_in        (src_in),
        .pc_sel        (pc_sel),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .cond_mode     (cond_mode),
        .alu_zero      (alu_zero),
        .alu_neg       (alu_neg),
        .exc_req       (exc_req),
        .exc_code      (exc_code),
        .pc_next       (pc_next),
        .pc_q          (pc_q),
        .epc_q         (epc_q),
        .cause_q       (cause_q),
        .trap_active   (trap_active),
        .sel_err       (sel_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic idle();
        reset = 0; pc_sel = 0; pc_write = 0; pc_write_cond = 0;
        cond_mode = 0; alu_zero = 0; alu_neg = 0; exc_req = 0; exc_code = 0;
    endtask

    task automatic set_src(input int k, input logic [W-1:0] v);
        src_in[k*W +: W] = v;
    endtask

    // Queue the state expected after the coming edge, then advance one cycle.
    task automatic step(input string name, input logic [W-1:0] pc, input logic [W-1:0] epc,
                        input logic [1:0] cause, input logic trap, input logic serr);
        exp_t e;
        e.name = name; e.pc = pc; e.epc = epc; e.cause = cause; e.trap = trap; e.serr = serr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".pc"},    pc_q,              e.pc);
                chk({e.name, ".epc"},   epc_q,             e.epc);
                chk({e.name, ".cause"}, W'(cause_q),       W'(e.cause));
                chk({e.name, ".trap"},  W'(trap_active),   W'(e.trap));
                chk({e.name, ".serr"},  W'(sel_err),       W'(e.serr));
            end
        end
    end

    initial begin : driver
        src_in = '0;
        idle();
        set_src(0, 32'h300); set_src(1, 32'h40); set_src(2, 32'h80);
        set_src(3, 32'h10);  set_src(4, 32'h42); set_src(5, 32'h200);
        reset = 1;
        step("rst0", 0, 0, 0, 0, 0);
        step("rst1", 0, 0, 0, 0, 0);

        idle(); pc_sel = 1; pc_write = 1;
        step("wr40", 32'h40, 0, 0, 0, 0);
        idle(); pc_sel = 2; pc_write_cond = 1; cond_mode = 1; alu_zero = 1;
        step("bne_nt", 32'h40, 0, 0, 0, 0);
        alu_zero = 0;
        step("bne_t", 32'h80, 0, 0, 0, 0);
        idle(); pc_sel = 3; pc_write_cond = 1; cond_mode = 0; alu_zero = 0;
        step("beq_nt", 32'h80, 0, 0, 0, 0);
        alu_zero = 1;
        step("beq_t", 32'h10, 0, 0, 0, 0);

        idle(); exc_req = 1; exc_code = 0; pc_write = 1; pc_sel = 1;
        step("exc_ovf", 32'h10, 32'h10, 0, 1, 0);
        idle(); pc_write = 1; pc_sel = 1; exc_req = 1; exc_code = 2;
        step("vec_ovf", 32'hFC, 32'h10, 0, 0, 0);

        idle(); pc_write = 1; pc_sel = 4;
        step("misalign", 32'hFC, 32'hFC, 3, 1, 0);
        idle();
        step("vec_align", 32'h108, 32'hFC, 3, 0, 0);

        idle(); pc_write_cond = 1; cond_mode = 2; alu_neg = 1; pc_sel = 5;
        step("blez_t", 32'h200, 32'hFC, 3, 0, 0);
        idle(); pc_write_cond = 1; cond_mode = 3; pc_sel = 0;
        step("bgtz_t", 32'h300, 32'hFC, 3, 0, 0);
        pc_sel = 1; alu_neg = 1;
        step("bgtz_nt", 32'h300, 32'hFC, 3, 0, 0);
        cond_mode = 2; alu_neg = 0;
        step("blez_nt", 32'h300, 32'hFC, 3, 0, 0);

        idle(); pc_write = 1; pc_sel = 7;
        step("sel7", 32'h300, 32'hFC, 3, 0, 1);
        pc_sel = 6;
        step("sel6", 32'h300, 32'hFC, 3, 0, 1);
        pc_sel = 1;
        step("sticky", 32'h40, 32'hFC, 3, 0, 1);

        idle(); exc_req = 1; exc_code = 2;
        step("exc_rsvd", 32'h40, 32'h40, 2, 1, 1);
        idle();
        step("vec_rsvd", 32'h104, 32'h40, 2, 0, 1);

        idle(); exc_req = 1; exc_code = 1;
        step("exc_opc", 32'h104, 32'h104, 1, 1, 1);
        idle(); reset = 1;
        step("rst_trap", 0, 0, 0, 0, 0);
        idle();
        step("post_rst", 0, 0, 0, 0, 0);

        drv_done = 1;
    end

    initial begin : finisher
        int guard;
        guard = 0;
        while (!drv_done && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if (!drv_done || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: done=%0d pending=%0d, expected done=1 pending=0", drv_done, exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
